mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM register outputs: valid, ALU result, dmem address and write data, funct3 opsel, and rd/mem control.
- Drives the data-memory request/response interface. Handles byte-lane alignment for stores and extraction/extension for loads.
- Stalls upstream while a memory transaction is outstanding, and drives the MEM/WB register toward writeback.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_stage.sv | 219 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access-size codes,
// FSM state encoding and byte-lane mask constants.
package mem_stage_pkg;

    // funct3[1:0] access size; any code with bit 1 set is a word
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] MASK_ALL = 4'b1111;
    localparam logic [3:0] MASK_LO  = 4'b0011;
    localparam logic [3:0] MASK_HI  = 4'b1100;
    localparam logic [3:0] MASK_B0  = 4'b0001;

    // Collapse funct3 to one of the three size codes
    function automatic logic [1:0] size_of(input logic [2:0] opsel);
        return opsel[1] ? SZ_W : opsel[1:0];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: store mask and data replication,
// load lane extraction with sign/zero extension. Purely combinational.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_opsel,
    input  logic        i_write,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [1:0]  w_size;
    logic [31:0] w_shift;

    assign w_size = size_of(i_opsel);

    // Store side: replicate the datum across all lanes, enable only the addressed ones
    always_comb begin
        o_mask  = MASK_ALL;
        o_wdata = i_wdata;
        case (w_size)
            SZ_B: begin
                o_wdata = {4{i_wdata[7:0]}};
                if (i_write) o_mask = MASK_B0 << i_addr_lo;
            end
            SZ_H: begin
                o_wdata = {2{i_wdata[15:0]}};
                if (i_write) o_mask = i_addr_lo[1] ? MASK_HI : MASK_LO;
            end
            default: begin
                o_wdata = i_wdata;
                o_mask  = MASK_ALL;
            end
        endcase
    end

    // Load side: move the addressed lane to bit 0, then extend (opsel[2] = unsigned)
    always_comb begin
        w_shift = i_rdata >> {i_addr_lo, 3'b000};
        o_ldata = w_shift;
        case (w_size)
            SZ_B:    o_ldata = {{24{w_shift[7] & ~i_opsel[2]}}, w_shift[7:0]};
            SZ_H:    o_ldata = {{16{w_shift[15] & ~i_opsel[2]}}, w_shift[15:0]};
            default: o_ldata = w_shift;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-memory requests, stalls upstream
// while a transaction is outstanding and drives the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 0
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_vld,
    input  logic [31:0] i_res,
    input  logic [4:0]  i_rd_waddr,
    input  logic        i_rd_wen,
    input  logic        i_mem_reg,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_opsel,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_req,
    input  logic        i_dmem_ready,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_vld,
    output logic [4:0]  o_rd_waddr,
    output logic        o_rd_wen,
    output logic [31:0] o_rd_wdata,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    // Counter value seen in the cycle where the TIMEOUT-th wait cycle elapses
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cnt;

    logic        r_dmem_wen;
    logic [31:0] r_dmem_addr;
    logic [3:0]  r_dmem_mask;
    logic [31:0] r_dmem_wdata;

    logic        r_vld;
    logic [4:0]  r_rd_waddr;
    logic        r_rd_wen;
    logic [31:0] r_rd_wdata;
    logic        r_mis;
    logic        r_berr;

    logic        w_memop;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_stall;
    logic [1:0]  w_size;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;

    logic        w_vld_n;
    logic        w_wen_n;
    logic        w_mis_n;
    logic        w_berr_n;
    logic [31:0] w_wdata_n;

    mem_lane_align u_align (
        .i_opsel   (i_opsel),
        .i_write   (i_mem_write),
        .i_addr_lo (i_dmem_addr[1:0]),
        .i_wdata   (i_dmem_wdata),
        .i_rdata   (i_dmem_rdata),
        .o_mask    (w_mask),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata)
    );

    assign w_size  = size_of(i_opsel);
    assign w_memop = i_vld & (i_mem_read | i_mem_write);

    // Half needs even address, word needs 4-byte alignment; bytes never fault
    always_comb begin
        case (w_size)
            SZ_H:    w_misaligned = i_dmem_addr[0];
            SZ_W:    w_misaligned = (i_dmem_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // ">=" so that a ready arriving on the last allowed cycle still gets a bounded RESP
    assign w_timeout = (TIMEOUT > 0) && (r_state != ST_IDLE) && (r_cnt >= TO_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a completing handshake wins over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_memop && !w_misaligned) w_next = ST_REQ;
            ST_REQ: begin
                if (i_dmem_ready)   w_next = r_dmem_wen ? ST_IDLE : ST_RESP;
                else if (w_timeout) w_next = ST_IDLE;
            end
            ST_RESP: if (i_dmem_rvalid || w_timeout) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output logic: upstream stall and the value headed into MEM/WB
    always_comb begin
        w_stall   = 1'b0;
        w_vld_n   = 1'b0;
        w_wen_n   = 1'b0;
        w_mis_n   = 1'b0;
        w_berr_n  = 1'b0;
        w_wdata_n = i_res;
        case (r_state)
            ST_IDLE: begin
                if (!w_memop) begin
                    w_vld_n = i_vld;
                    w_wen_n = i_rd_wen;
                end else if (w_misaligned) begin
                    w_vld_n = 1'b1;
                    w_mis_n = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_REQ: begin
                if (i_dmem_ready && r_dmem_wen) begin
                    w_vld_n = 1'b1;
                end else if (i_dmem_ready) begin
                    w_stall = 1'b1;
                end else if (w_timeout) begin
                    w_vld_n  = 1'b1;
                    w_berr_n = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_dmem_rvalid) begin
                    w_vld_n = 1'b1;
                    w_wen_n = i_rd_wen;
                    if (i_mem_reg) w_wdata_n = w_ldata;
                end else if (w_timeout) begin
                    w_vld_n  = 1'b1;
                    w_berr_n = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Wait counter: counts REQ/RESP cycles, cleared whenever heading back to IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst || (TIMEOUT == 0) || (w_next == ST_IDLE)) r_cnt <= '0;
        else if (r_state != ST_IDLE)                         r_cnt <= r_cnt + 32'd1;
    end

    // Capture the request once; it stays frozen on the bus until accepted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dmem_wen   <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_mask  <= '0;
            r_dmem_wdata <= '0;
        end else if ((r_state == ST_IDLE) && w_memop && !w_misaligned) begin
            r_dmem_wen   <= i_mem_write;
            r_dmem_addr  <= {i_dmem_addr[31:2], 2'b00};
            r_dmem_mask  <= w_mask;
            r_dmem_wdata <= w_wdata;
        end
    end

    // MEM/WB register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld      <= 1'b0;
            r_rd_waddr <= '0;
            r_rd_wen   <= 1'b0;
            r_rd_wdata <= '0;
            r_mis      <= 1'b0;
            r_berr     <= 1'b0;
        end else begin
            r_vld      <= w_vld_n;
            r_rd_waddr <= i_rd_waddr;
            r_rd_wen   <= w_wen_n;
            r_rd_wdata <= w_wdata_n;
            r_mis      <= w_mis_n;
            r_berr     <= w_berr_n;
        end
    end

    assign o_stall      = w_stall & ~i_rst;
    assign o_dmem_req   = (r_state == ST_REQ);
    assign o_dmem_wen   = r_dmem_wen;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_mask  = r_dmem_mask;
    assign o_dmem_wdata = r_dmem_wdata;
    assign o_vld        = r_vld;
    assign o_rd_waddr   = r_rd_waddr;
    assign o_rd_wen     = r_rd_wen;
    assign o_rd_wdata   = r_rd_wdata;
    assign o_misaligned = r_mis;
    assign o_bus_err    = r_berr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level retire model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_vld;
    logic [31:0] i_res;
    logic [4:0]  i_rd_waddr;
    logic        i_rd_wen;
    logic        i_mem_reg;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_opsel;
    logic [31:0] i_dmem_addr;
    logic [31:0] i_dmem_wdata;
    logic        o_dmem_req;
    logic        i_dmem_ready;
    logic        o_dmem_wen;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_stall;
    logic        o_vld;
    logic [4:0]  o_rd_waddr;
    logic        o_rd_wen;
    logic [31:0] o_rd_wdata;
    logic        o_misaligned;
    logic        o_bus_err;

    always #5 i_clk = ~i_clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .i_res(i_res),
        .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_mem_reg(i_mem_reg),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_opsel(i_opsel),
        .i_dmem_addr(i_dmem_addr), .i_dmem_wdata(i_dmem_wdata),
        .o_dmem_req(o_dmem_req), .i_dmem_ready(i_dmem_ready), .o_dmem_wen(o_dmem_wen),
        .o_dmem_addr(o_dmem_addr), .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_stall(o_stall), .o_vld(o_vld), .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen),
        .o_rd_wdata(o_rd_wdata), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          cyc;
        logic [4:0]  waddr;
        logic        wen;
        logic [31:0] wdata;
        logic        mis;
        logic        berr;
    } ret_t;

    ret_t expq[$];
    ret_t cur;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference rules written from the architectural description
    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] a, input logic [2:0] op);
        logic [31:0] s;
        s = rd >> (8 * a);
        if (op[1]) return s;
        if (op[0]) begin
            s = s % 65536;
            if (!op[2] && s >= 32768) s = s + 32'hFFFF0000;
        end else begin
            s = s % 256;
            if (!op[2] && s >= 128) s = s + 32'hFFFFFF00;
        end
        return s;
    endfunction

    function automatic logic [3:0] m_mask(input logic wr, input logic [2:0] op, input logic [1:0] a);
        if (!wr || op[1]) return 4'hF;
        if (op[0])        return a[1] ? 4'hC : 4'h3;
        return 4'b0001 << a;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        if (op[1]) return wd;
        if (op[0]) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return {24'h0, wd[7:0]} * 32'h0101_0101;
    endfunction

    function automatic logic m_mis(input logic [2:0] op, input logic [1:0] a);
        if (op[1]) return a != 2'b00;
        if (op[0]) return a[0];
        return 1'b0;
    endfunction

    // Retire monitor: o_vld must appear exactly when the model says, with matching fields
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                cur = expq.pop_front();
                chk("ret_vld",  o_vld,        1);
                chk("ret_wen",  o_rd_wen,     cur.wen);
                chk("ret_mis",  o_misaligned, cur.mis);
                chk("ret_berr", o_bus_err,    cur.berr);
                if (cur.wen) begin
                    chk("ret_waddr", o_rd_waddr, cur.waddr);
                    chk("ret_wdata", o_rd_wdata, cur.wdata);
                end
            end else begin
                chk("bubble_vld",  o_vld,        0);
                chk("bubble_mis",  o_misaligned, 0);
                chk("bubble_berr", o_bus_err,    0);
            end
        end
    end

    task automatic idle(input int n, input logic stray);
        for (int i = 0; i < n; i++) begin
            i_vld = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
            i_dmem_rvalid = stray; i_dmem_rdata = 32'h5555_AAAA;
            @(negedge i_clk);
            chk("idle_stall", o_stall, 0);
            chk("idle_req", o_dmem_req, 0);
            @(posedge i_clk); #1;
            i_dmem_rvalid = 1'b0;
        end
    endtask

    // Present one EX/MEM entry and play the memory side of the handshake
    task automatic run_op(input string nm, input logic [31:0] res, input logic [4:0] rd,
                          input logic rwen, input logic mreg, input logic rd_op, input logic wr_op,
                          input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int rwait, input int vwait, input logic [31:0] rdata,
                          input logic stray);
        ret_t e;
        int   k, total, n;
        bit   memop, mis, tout, in_req, done, to_now;
        i_vld = 1'b1; i_res = res; i_rd_waddr = rd; i_rd_wen = rwen; i_mem_reg = mreg;
        i_mem_read = rd_op; i_mem_write = wr_op; i_opsel = op;
        i_dmem_addr = addr; i_dmem_wdata = wd;
        k = cyc;
        memop = rd_op | wr_op;
        mis   = memop && m_mis(op, addr[1:0]);
        e.waddr = rd; e.wdata = res; e.wen = 1'b0; e.mis = 1'b0; e.berr = 1'b0;
        if (!memop) begin
            e.cyc = k + 1; e.wen = rwen;
        end else if (mis) begin
            e.cyc = k + 1; e.mis = 1'b1;
        end else if (wr_op) begin
            tout = (rwait >= TO);
            e.cyc = tout ? k + 1 + TO : k + 2 + rwait;
            e.berr = tout;
        end else begin
            tout = (rwait >= TO) || (rwait + vwait + 2 > TO);
            e.cyc = tout ? k + 1 + TO : k + 3 + rwait + vwait;
            e.berr = tout;
            if (!tout) begin
                e.wen = rwen;
                e.wdata = mreg ? m_load(rdata, addr[1:0], op) : res;
            end
        end
        expq.push_back(e);

        @(negedge i_clk);
        chk({nm, "_stall_idle"}, o_stall, (memop && !mis) ? 1 : 0);
        chk({nm, "_req_idle"}, o_dmem_req, 0);
        @(posedge i_clk); #1;

        if (memop && !mis) begin
            total = 0; n = 0; in_req = 1'b1;
            forever begin
                total++;
                if (in_req) begin
                    i_dmem_ready  = (n == rwait);
                    i_dmem_rvalid = stray && (n == rwait);
                    i_dmem_rdata  = 32'hDEAD_DEAD;
                end else begin
                    i_dmem_ready  = 1'b0;
                    i_dmem_rvalid = (n == vwait);
                    i_dmem_rdata  = (n == vwait) ? rdata : 32'h0BAD_0BAD;
                end
                @(negedge i_clk);
                done   = in_req ? (n == rwait && wr_op) : (n == vwait);
                to_now = !done && !(in_req && n == rwait) && (total >= TO);
                if (in_req) begin
                    chk({nm, "_req"},   o_dmem_req,   1);
                    chk({nm, "_wen"},   o_dmem_wen,   wr_op);
                    chk({nm, "_addr"},  o_dmem_addr,  {addr[31:2], 2'b00});
                    chk({nm, "_mask"},  o_dmem_mask,  m_mask(wr_op, op, addr[1:0]));
                    if (wr_op) chk({nm, "_wdata"}, o_dmem_wdata, m_wdata(op, wd));
                end else begin
                    chk({nm, "_req_resp"}, o_dmem_req, 0);
                end
                chk({nm, "_stall"}, o_stall, (done || to_now) ? 0 : 1);
                @(posedge i_clk); #1;
                i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
                if (done || to_now) break;
                if (total > 200) begin
                    chk({nm, "_bound"}, total, 0);
                    break;
                end
                if (in_req && n == rwait) begin
                    in_req = 1'b0; n = 0;
                end else begin
                    n++;
                end
            end
        end
        i_vld = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_vld = 1'b0; i_res = '0; i_rd_waddr = '0; i_rd_wen = 1'b0;
        i_mem_reg = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_opsel = '0;
        i_dmem_addr = '0; i_dmem_wdata = '0; i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;

        // Hand-computed literals pinning the reference rules
        chk("pin_lh",    m_load(32'h8001_7FFF, 2'd2, 3'b001), 32'hFFFF_8001);
        chk("pin_lhu",   m_load(32'h8001_7FFF, 2'd2, 3'b101), 32'h0000_8001);
        chk("pin_lb",    m_load(32'h1122_8344, 2'd1, 3'b000), 32'hFFFF_FF83);
        chk("pin_lbu",   m_load(32'hF000_0000, 2'd3, 3'b100), 32'h0000_00F0);
        chk("pin_sbmsk", m_mask(1'b1, 3'b000, 2'd3), 4'b1000);
        chk("pin_sbdat", m_wdata(3'b000, 32'h0000_00AB), 32'hABAB_ABAB);
        chk("pin_shdat", m_wdata(3'b001, 32'h0000_5678), 32'h5678_5678);
        chk("pin_lwmis", m_mis(3'b010, 2'd1), 1);

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_stall", o_stall, 0);
        chk("rst_req",   o_dmem_req, 0);
        chk("rst_vld",   o_vld, 0);
        chk("rst_addr",  o_dmem_addr, 0);
        chk("rst_mask",  o_dmem_mask, 0);
        chk("rst_wdata", o_dmem_wdata, 0);
        chk("rst_wen",   o_rd_wen, 0);
        chk("rst_rdw",   o_rd_wdata, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        mon_en = 1'b1;

        //     name    res           rd  wen mreg rd wr op      addr          wdata         rw  vw  rdata        stray
        run_op("alu",  32'h1234,     5,  1,  0,   0, 0, 3'b000, 32'h0,        32'h0,        0,  0,  32'h0,       0);
        run_op("sb",   32'h0,        0,  0,  0,   0, 1, 3'b000, 32'h103,      32'hAB,       0,  0,  32'h0,       0);
        run_op("lh",   32'h0,        7,  1,  1,   1, 0, 3'b001, 32'h102,      32'h0,        2,  0,  32'h8001_7FFF, 1);
        run_op("lhu",  32'h0,        8,  1,  1,   1, 0, 3'b101, 32'h102,      32'h0,        2,  0,  32'h8001_7FFF, 0);
        run_op("lwmis",32'h0,        9,  1,  1,   1, 0, 3'b010, 32'h101,      32'h0,        0,  0,  32'h0,       0);
        idle(2, 1'b1);
        run_op("lwto", 32'h0,        10, 1,  1,   1, 0, 3'b010, 32'h100,      32'h0,        100,0,  32'h0,       0);
        run_op("lb",   32'h0,        11, 1,  1,   1, 0, 3'b000, 32'h201,      32'h0,        0,  1,  32'h1122_8344, 0);
        run_op("sh",   32'h0,        0,  0,  0,   0, 1, 3'b001, 32'h202,      32'h5678,     1,  0,  32'h0,       0);
        run_op("sw",   32'h0,        0,  0,  0,   0, 1, 3'b010, 32'h204,      32'hDEAD_BEEF,0,  0,  32'h0,       0);
        run_op("lbu",  32'h0,        12, 1,  1,   1, 0, 3'b100, 32'h203,      32'h0,        0,  0,  32'hF000_0000, 0);
        run_op("ldres",32'h7777,     13, 1,  0,   1, 0, 3'b010, 32'h208,      32'h0,        1,  0,  32'h1111_2222, 0);
        run_op("shmis",32'h0,        0,  0,  0,   0, 1, 3'b001, 32'h301,      32'h1,        0,  0,  32'h0,       0);
        run_op("rspto",32'h0,        14, 1,  1,   1, 0, 3'b010, 32'h300,      32'h0,        0,  100,32'h0,       0);
        run_op("swto", 32'h0,        0,  0,  0,   0, 1, 3'b010, 32'h304,      32'h1,        100,0,  32'h0,       0);
        run_op("alu2", 32'hCAFE_0001,31, 1,  0,   0, 0, 3'b000, 32'h0,        32'h0,        0,  0,  32'h0,       0);
        idle(2, 1'b0);

        // Reset while waiting in RESP; a late response must be dropped
        i_vld = 1'b1; i_mem_read = 1'b1; i_mem_reg = 1'b1; i_rd_wen = 1'b1;
        i_rd_waddr = 5'd9; i_opsel = 3'b010; i_dmem_addr = 32'h400; i_res = '0;
        @(posedge i_clk); #1;
        i_dmem_ready = 1'b1;
        @(posedge i_clk); #1;
        i_dmem_ready = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_mid_stall", o_stall, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_vld = 1'b0; i_mem_read = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_req",   o_dmem_req, 0);
        chk("rst_mid_wen",   o_dmem_wen, 0);
        chk("rst_mid_addr",  o_dmem_addr, 0);
        chk("rst_mid_mask",  o_dmem_mask, 0);
        chk("rst_mid_rdwen", o_rd_wen, 0);
        chk("rst_mid_rdw",   o_rd_wdata, 0);
        idle(2, 1'b1);
        run_op("lwpost", 32'h0, 15, 1, 1, 1, 0, 3'b010, 32'h400, 32'h0, 0, 0, 32'hCAFE_BABE, 0);
        idle(3, 1'b0);

        chk("drain", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
